// File: rtl/branch_resolution_queue_pkg.sv
// Shared constants and types for the branch resolution queue.
package branch_resolution_queue_pkg;

    // PC width and instruction stride; the stride matches the predictor's pc[2 +: INDEX_LEN] indexing.
    localparam int              PC_W            = 16;
    localparam logic [PC_W-1:0] INSTR_STRIDE    = 16'd4;
    localparam int              DEFAULT_PTR_LEN = 2;

    // One in-flight branch: its PC and the predicted direction (1 = taken).
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            prediction;
    } brq_entry_t;

    // Sequential (not-taken) successor of a branch; wraps modulo 2^16.
    function automatic logic [PC_W-1:0] fallthrough_pc(input logic [PC_W-1:0] pc);
        return pc + INSTR_STRIDE;
    endfunction

endpackage

// File: rtl/branch_resolution_queue_storage.sv
// Entry storage for the branch resolution queue: one write port at the tail,
// one combinational read port at the head. Contents are not reset.
module branch_queue_storage
    import branch_resolution_queue_pkg::*;
#(
    parameter int PTR_LEN = DEFAULT_PTR_LEN
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [PTR_LEN-1:0] wr_ptr,
    input  brq_entry_t         wr_data,
    input  logic [PTR_LEN-1:0] rd_ptr,
    output brq_entry_t         rd_data
);

    localparam int DEPTH = 1 << PTR_LEN;

    brq_entry_t mem_q [DEPTH];
    brq_entry_t mem_d [DEPTH];

    // Next array contents: only the tail slot changes, and only on a push.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = wr_data;
        end
    end

    // Array register; data only, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/branch_resolution_queue.sv
// In-order tracker of in-flight conditional branches. Allocates at fetch,
// resolves oldest-first, drives the predictor update and a registered
// mispredict/redirect that flushes every younger entry.
module branch_resolution_queue
    import branch_resolution_queue_pkg::*;
#(
    parameter int PTR_LEN = DEFAULT_PTR_LEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_valid,
    input  logic [PC_W-1:0]     alloc_pc,
    input  logic                alloc_prediction,
    output logic                alloc_ready,
    input  logic                resolve_valid,
    input  logic                resolve_taken,
    input  logic [PC_W-1:0]     resolve_target,
    output logic                upd_write_enabled,
    output logic                upd_outcome,
    output logic [PC_W-1:0]     upd_pc,
    output logic                mispredict,
    output logic [PC_W-1:0]     redirect_pc,
    output logic [PTR_LEN:0]    count,
    output logic                empty
);

    localparam logic [PTR_LEN:0]   DEPTH_C   = (PTR_LEN+1)'(1 << PTR_LEN);
    localparam logic [PTR_LEN:0]   CNT_ONE   = (PTR_LEN+1)'(1);
    localparam logic [PTR_LEN-1:0] PTR_ONE   = PTR_LEN'(1);

    logic [PTR_LEN-1:0] head_q, head_d;
    logic [PTR_LEN-1:0] tail_q, tail_d;
    logic [PTR_LEN:0]   count_q, count_d;
    logic               upd_we_q, upd_we_d;
    logic               upd_outcome_q, upd_outcome_d;
    logic [PC_W-1:0]    upd_pc_q, upd_pc_d;
    logic               mispredict_q, mispredict_d;
    logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;

    brq_entry_t head_entry;
    brq_entry_t wr_entry;
    logic       do_push;
    logic       do_pop;
    logic       do_flush;

    assign wr_entry = '{pc: alloc_pc, prediction: alloc_prediction};

    branch_queue_storage #(
        .PTR_LEN (PTR_LEN)
    ) u_storage (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_ptr  (tail_q),
        .wr_data (wr_entry),
        .rd_ptr  (head_q),
        .rd_data (head_entry)
    );

    // Readiness uses start-of-cycle occupancy, so a full queue refuses a push even while popping.
    assign alloc_ready = (count_q < DEPTH_C) && !mispredict_q;
    assign empty       = (count_q == '0);
    assign count       = count_q;

    // Pop/push/flush decisions plus next pointer, count and output-register values.
    always_comb begin
        do_pop   = resolve_valid && !empty;
        do_flush = do_pop && (resolve_taken != head_entry.prediction);
        do_push  = alloc_valid && alloc_ready && !do_flush;

        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        upd_we_d      = do_pop;
        upd_outcome_d = upd_outcome_q;
        upd_pc_d      = upd_pc_q;
        mispredict_d  = do_flush;
        redirect_pc_d = redirect_pc_q;

        if (do_pop) begin
            upd_outcome_d = resolve_taken;
            upd_pc_d      = head_entry.pc;
        end

        if (do_flush) begin
            // Everything younger than the resolved branch is wrong-path.
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            redirect_pc_d = resolve_taken ? resolve_target : fallthrough_pc(head_entry.pc);
        end else begin
            if (do_pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (do_push) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            upd_we_q      <= 1'b0;
            upd_outcome_q <= 1'b0;
            upd_pc_q      <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            upd_we_q      <= upd_we_d;
            upd_outcome_q <= upd_outcome_d;
            upd_pc_q      <= upd_pc_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign upd_write_enabled = upd_we_q;
    assign upd_outcome       = upd_outcome_q;
    assign upd_pc            = upd_pc_q;
    assign mispredict        = mispredict_q;
    assign redirect_pc       = redirect_pc_q;

endmodule
